// File: rtl/fir_decim_out.sv
// Accumulate-and-dump decimator with rounding, arithmetic scaling and saturation.
// Results are queued in a show-ahead FIFO that the consumer drains with a valid/ready handshake.
module fir_decim_out #(
  parameter int IN_W       = 16,
  parameter int OUT_W      = 8,
  parameter int DECIM      = 4,
  parameter int SHIFT      = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   i_valid,
  input  logic signed [IN_W-1:0] i_sample,
  output logic                   o_valid,
  output logic [OUT_W-1:0]       o_data,
  input  logic                   i_ready,
  output logic                   o_sat,
  output logic                   o_ovf,
  input  logic                   i_clr_ovf
);
  localparam int ACC_W = IN_W + $clog2(DECIM) + 1;
  localparam int RW    = ACC_W + 1;  // one spare bit so adding the rounding constant cannot wrap
  localparam int CW    = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic signed [RW-1:0] RND  = (RW'(1) << SHIFT) >> 1;
  localparam logic signed [RW-1:0] SMAX = (RW'(1) << (OUT_W - 1)) - RW'(1);
  localparam logic signed [RW-1:0] SMIN = ~SMAX;

  logic signed [ACC_W-1:0] acc;
  logic [CW-1:0]           cnt;
  logic signed [RW-1:0]    sum, r;
  logic                    dump, clip;
  logic [OUT_W-1:0]        res;

  logic [OUT_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]    wp, rp;
  logic [AW:0]      level;
  logic             full, push, pop;

  always_comb begin
    dump = i_valid && (cnt == CW'(DECIM - 1));
    sum  = {{(RW-ACC_W){acc[ACC_W-1]}}, acc} + {{(RW-IN_W){i_sample[IN_W-1]}}, i_sample};
    r    = (sum + RND) >>> SHIFT;
    clip = 1'b0;
    res  = r[OUT_W-1:0];
    if (r > SMAX) begin
      clip = 1'b1;
      res  = SMAX[OUT_W-1:0];
    end else if (r < SMIN) begin
      clip = 1'b1;
      res  = SMIN[OUT_W-1:0];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc <= '0;
      cnt <= '0;
    end else if (dump) begin
      acc <= '0;
      cnt <= '0;
    end else if (i_valid) begin
      acc <= acc + {{(ACC_W-IN_W){i_sample[IN_W-1]}}, i_sample};
      cnt <= cnt + CW'(1);
    end
  end

  // A push into a full FIFO still succeeds when the head is popped on the same edge.
  always_comb begin
    full    = (level == (AW+1)'(FIFO_DEPTH));
    o_valid = (level != '0);
    o_data  = o_valid ? mem[rp] : '0;
    pop     = o_valid && i_ready;
    push    = dump && (!full || pop);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wp    <= '0;
      rp    <= '0;
      level <= '0;
    end else begin
      if (push) begin
        mem[wp] <= res;
        wp      <= (wp == AW'(FIFO_DEPTH - 1)) ? '0 : wp + AW'(1);
      end
      if (pop) rp <= (rp == AW'(FIFO_DEPTH - 1)) ? '0 : rp + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      o_sat <= 1'b0;
      o_ovf <= 1'b0;
    end else begin
      o_sat <= dump && clip;
      if (dump && !push)  o_ovf <= 1'b1;
      else if (i_clr_ovf) o_ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fir_decim_out.sv
// Directed bench for fir_decim_out: an expected-output queue is filled as blocks
// are driven and drained by a monitor whenever the DUT hands over a sample.
module tb_fir_decim_out;
  logic              clock = 1'b0;
  logic              reset_n, i_valid, i_ready, i_clr_ovf;
  logic signed [15:0] i_sample;
  logic              o_valid, o_sat, o_ovf;
  logic [7:0]        o_data;

  int ncmp = 0;
  int nerr = 0;
  int sb[$];

  fir_decim_out #(.IN_W(16), .OUT_W(8), .DECIM(4), .SHIFT(2), .FIFO_DEPTH(4)) dut (
    .clock(clock), .reset_n(reset_n), .i_valid(i_valid), .i_sample(i_sample),
    .o_valid(o_valid), .o_data(o_data), .i_ready(i_ready), .o_sat(o_sat),
    .o_ovf(o_ovf), .i_clr_ovf(i_clr_ovf)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: round half up, divide by 4, clip to signed 8 bits.
  function automatic int model(input int s);
    int r;
    r = (s + 2) >>> 2;
    if (r > 127)  r = 127;
    if (r < -128) r = -128;
    return r;
  endfunction

  always @(negedge clock) begin
    if (reset_n && o_valid && i_ready) begin
      if (sb.size() == 0) begin
        ncmp++;
        nerr++;
        $error("FAIL spurious_out: observed data %0d with no expected entry", $signed(o_data));
      end else begin
        chk("data", $signed(o_data), sb.pop_front());
      end
    end
  end

  task automatic drive(input bit v, input int s);
    @(posedge clock);
    #1;
    i_valid  = v;
    i_sample = 16'(s);
  endtask

  task automatic blk(input int a, b, c, d, input bit exp_push);
    if (exp_push) sb.push_back(model(a + b + c + d));
    drive(1, a); drive(1, b); drive(1, c); drive(1, d);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 64) begin
      @(negedge clock);
      n++;
    end
    @(posedge clock);
    chk("drain_left", sb.size(), 0);
  endtask

  initial begin
    reset_n = 1'b0; i_valid = 1'b0; i_sample = '0; i_ready = 1'b1; i_clr_ovf = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock);
    chk("rst_valid", o_valid, 0);
    chk("rst_data", o_data, 0);
    chk("rst_sat", o_sat, 0);
    chk("rst_ovf", o_ovf, 0);

    // single block, one-cycle latency, single valid pulse
    blk(4, 4, 4, 4, 1);
    drive(0, 0);
    @(negedge clock);
    chk("t1_latency_valid", o_valid, 1);
    chk("t1_sat", o_sat, 0);
    @(negedge clock);
    chk("t1_valid_pulse", o_valid, 0);

    // negative rounding and small-value rounding
    blk(-3, -3, -3, -3, 1);
    blk(1, 1, 0, 0, 1);
    drive(0, 0);
    drain();

    // saturation both ways
    blk(1000, 1000, 1000, 1000, 1);
    drive(0, 0);
    @(negedge clock);
    chk("t3_sat_pos", o_sat, 1);
    @(negedge clock);
    chk("t3_sat_pulse_end", o_sat, 0);
    blk(-1000, -1000, -1000, -1000, 1);
    drive(0, 0);
    @(negedge clock);
    chk("t3_sat_neg", o_sat, 1);
    drain();

    // backpressure: fill, overflow, hold, drain in order, clear
    drive(0, 0);
    i_ready = 1'b0;
    for (int v = 1; v <= 5; v++) blk(v, v, v, v, v < 5);
    drive(0, 0);
    @(negedge clock);
    chk("t4_ovf_set", o_ovf, 1);
    chk("t4_head", $signed(o_data), 1);
    repeat (3) drive(0, 0);
    @(negedge clock);
    chk("t4_head_held", $signed(o_data), 1);
    chk("t4_valid_held", o_valid, 1);
    drive(0, 0);
    i_ready = 1'b1;
    drain();
    chk("t4_ovf_sticky", o_ovf, 1);
    drive(0, 0);
    i_clr_ovf = 1'b1;
    drive(0, 0);
    i_clr_ovf = 1'b0;
    @(negedge clock);
    chk("t4_ovf_clr", o_ovf, 0);

    // gaps inside a block
    sb.push_back(model(28));
    drive(1, 7); drive(0, 0); drive(1, 7); drive(0, 0); drive(0, 0); drive(1, 7); drive(1, 7);
    drive(0, 0);
    @(negedge clock);
    chk("t5_gap_valid", o_valid, 1);
    drain();

    // push and pop on the same edge while full
    drive(0, 0);
    i_ready = 1'b0;
    for (int v = 10; v <= 13; v++) blk(v, v, v, v, 1);
    sb.push_back(model(56));
    drive(1, 14); drive(1, 14); drive(1, 14); drive(1, 14);
    i_ready = 1'b1;
    drive(0, 0);
    @(negedge clock);
    chk("t5_full_pushpop_ovf", o_ovf, 0);
    drain();

    // async reset mid-block flushes FIFO and partial sum
    drive(0, 0);
    i_ready = 1'b0;
    blk(9, 9, 9, 9, 1);
    drive(0, 0);
    @(negedge clock);
    chk("t6_pre_valid", o_valid, 1);
    drive(1, 100); drive(1, 100);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_rst_valid", o_valid, 0);
    chk("t6_rst_data", o_data, 0);
    sb.delete();
    drive(0, 0);
    reset_n = 1'b1;
    i_ready = 1'b1;
    blk(8, 8, 8, 8, 1);
    drive(0, 0);
    drain();
    chk("t6_ovf", o_ovf, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
